// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR MAC engine.
package fir_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int ACC_W  = 40;

  // Q1.15 coefficients: products carry 15 fractional bits
  localparam int FRAC = 15;

  // Output clamp limits for a DATA_W-bit signed result
  localparam int SAT_MAX = (1 << (DATA_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (DATA_W - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate datapath: full-width product, sign-extended accumulate,
// round-half-up by 2^(FRAC-1), arithmetic shift and saturation into out register.
module fir_mac #(
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int COEF_W = fir_pkg::COEF_W,
  parameter int ACC_W  = fir_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic                     i_last,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [COEF_W-1:0] i_h,
  output logic signed [DATA_W-1:0] o_data
);
  import fir_pkg::*;

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] LIM_MAX = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] LIM_MIN = ACC_W'(SAT_MIN);
  localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(1 << (FRAC - 1));

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_rnd;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [DATA_W-1:0] w_sat;

  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W-1:0] r_data;

  // Product, running sum including this tap, and its scaled/clamped form
  always_comb begin
    w_prod  = PROD_W'(i_x) * PROD_W'(i_h);
    w_sum   = r_acc + $signed({{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod});
    w_rnd   = w_sum + ROUND;
    w_shift = w_rnd >>> FRAC;
    if (w_shift > LIM_MAX) begin
      w_sat = LIM_MAX[DATA_W-1:0];
    end else if (w_shift < LIM_MIN) begin
      w_sat = LIM_MIN[DATA_W-1:0];
    end else begin
      w_sat = w_shift[DATA_W-1:0];
    end
  end

  // Accumulator clears on a new sample; result register loads on the last tap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_data <= '0;
    end else begin
      if (i_clr) begin
        r_acc <= '0;
      end else if (i_en) begin
        r_acc <= w_sum;
      end
      if (i_en && i_last) begin
        r_data <= w_sat;
      end
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/fir_mac_engine.sv
// Serial FIR filter: pops one sample from a show-ahead FIFO, runs NTAPS
// multiply-accumulates (one per cycle) and holds the result until accepted.
module fir_mac_engine #(
  parameter int NTAPS  = 8,
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int COEF_W = fir_pkg::COEF_W,
  parameter int ACC_W  = fir_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  input  logic [DATA_W-1:0]        fifo_rd_data,
  output logic                     fifo_rd_en,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);
  import fir_pkg::*;

  localparam int ADDR_W = $clog2(NTAPS);

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_tap;
  logic [DATA_W-1:0]   r_x [NTAPS];
  logic [COEF_W-1:0]   r_h [NTAPS];

  logic                w_pop;
  logic                w_last;
  logic                w_mac_en;
  logic                w_coef_wr;
  logic [DATA_W-1:0]   w_mac_data;

  assign w_mac_en   = (r_state == MAC);
  assign w_last     = w_mac_en && (r_tap == ADDR_W'(NTAPS - 1));
  assign fifo_rd_en = (r_state == IDLE) && !fifo_empty && !rst;
  assign w_pop      = fifo_rd_en;
  // Coefficients are frozen while a pass is in flight
  assign w_coef_wr  = (r_state == IDLE) && coef_we && (int'(coef_addr) < NTAPS);

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (!fifo_empty) w_state_next = MAC;
      MAC:     if (w_last)      w_state_next = OUT;
      OUT:     if (out_ready)   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register; reset discards any pass in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Tap index restarts on every pop and advances once per MAC cycle
  always_ff @(posedge clk) begin
    if (rst || w_pop) begin
      r_tap <= '0;
    end else if (w_mac_en) begin
      r_tap <= w_last ? '0 : r_tap + 1'b1;
    end
  end

  // Delay line: x[0] is the newest sample
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) r_x[k] <= '0;
    end else if (w_pop) begin
      r_x[0] <= fifo_rd_data;
      for (int k = 1; k < NTAPS; k++) r_x[k] <= r_x[k-1];
    end
  end

  // Coefficient bank
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) r_h[k] <= '0;
    end else if (w_coef_wr) begin
      r_h[coef_addr] <= coef_data;
    end
  end

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_pop),
    .i_en   (w_mac_en),
    .i_last (w_last),
    .i_x    (r_x[r_tap]),
    .i_h    (r_h[r_tap]),
    .o_data (w_mac_data)
  );

  assign out_data  = w_mac_data;
  assign out_valid = (r_state == OUT);
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fir_mac_engine.sv
// Scoreboard bench for fir_mac_engine: a FIFO model feeds samples, a reference
// filter model predicts each output, a negedge monitor checks what the DUT presents.
module tb_fir_mac_engine;

  localparam int NT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_rd_data = 16'h0;
  logic        fifo_rd_en;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = 3'd0;
  logic [15:0] coef_data = 16'h0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  fir_mac_engine #(.NTAPS(NT)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  bit          gate_closed = 1'b1;
  bit          stream_chk = 1'b0;
  bit          last_pop = 1'b0;
  int          mx[NT];
  int          mh[NT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference filter: plain integer dot product, round, shift, clamp
  function automatic logic [15:0] ref_out();
    longint acc = 0;
    for (int i = 0; i < NT; i++) acc += longint'(mx[i]) * longint'(mh[i]);
    acc = (acc + 16384) >>> 15;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return acc[15:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      mx[i] = 0;
      mh[i] = 0;
    end
  endtask

  task automatic upd_fifo();
    fifo_empty   = gate_closed || (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0;
  endtask

  // One clock: record a pop before the edge, retire it from the FIFO after
  task automatic step();
    bit p;
    @(negedge clk);
    p = fifo_rd_en && !rst;
    if (p) begin
      for (int k = NT - 1; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = int'($signed(fifo_rd_data));
      exp_q.push_back(ref_out());
    end
    @(posedge clk);
    #1;
    if (p && fifo_q.size() > 0) void'(fifo_q.pop_front());
    upd_fifo();
    last_pop = p;
  endtask

  // Write every model coefficient into the DUT (engine must be idle)
  task automatic load_mh();
    for (int i = 0; i < NT; i++) begin
      coef_we   = 1'b1;
      coef_addr = 3'(i);
      coef_data = 16'(mh[i]);
      step();
    end
    coef_we = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    gate_closed = 1'b0;
    out_ready   = 1'b1;
    upd_fifo();
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && !busy) && n < budget) begin
      step();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  task automatic run_stream(input int budget);
    stream_chk = 1'b0;
    step();
    stream_chk = 1'b1;
    drain(budget);
    stream_chk = 1'b0;
  endtask

  task automatic wait_pop(input int budget);
    int n = 0;
    last_pop = 1'b0;
    while (!last_pop && n < budget) begin
      step();
      n++;
    end
    chk("pop_seen", last_pop, 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Output monitor
  initial begin
    bit pv = 1'b0;
    bit prev_stream = 1'b0;
    int pop_c = 0;
    int prev_pop = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        prev_stream = 1'b0;
        continue;
      end
      if (!stream_chk) prev_stream = 1'b0;
      if (fifo_rd_en) begin
        if (stream_chk && prev_stream) chk("pop_interval", cyc - prev_pop, NT + 2);
        prev_pop    = cyc;
        prev_stream = stream_chk;
        pop_c       = cyc;
      end
      if (out_valid) begin
        chk("no_pop_in_out", fifo_rd_en, 0);
        chk("busy_in_out", busy, 1);
        if (!pv) chk("latency", cyc - pop_c, NT + 1);
        else if (exp_q.size() > 0) chk("hold_data", out_data, exp_q[0]);
        if (out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_output", exp_q.size(), 1);
          else chk("out_data", out_data, exp_q.pop_front());
        end
      end
      pv = out_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int n;
    model_reset();
    // Reset: rd_en must stay low even with data offered
    fifo_q.push_back(16'h1234);
    gate_closed = 1'b0;
    upd_fifo();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    fifo_q.delete();
    gate_closed = 1'b1;
    upd_fifo();
    rst = 1'b0;
    step();

    // Impulse response
    mh[0] = 32'h2000;
    mh[1] = 32'h1000;
    load_mh();
    fifo_q.push_back(16'h4000);
    repeat (7) fifo_q.push_back(16'h0000);
    run_stream(200);

    // Saturation both ways
    for (int i = 0; i < NT; i++) mh[i] = 32'h7FFF;
    load_mh();
    repeat (8) fifo_q.push_back(16'h7FFF);
    repeat (8) fifo_q.push_back(16'h8000);
    run_stream(400);

    // Backpressure
    for (int i = 0; i < NT; i++) mh[i] = int'($signed(16'($urandom)));
    load_mh();
    gate_closed = 1'b1;
    out_ready = 1'b0;
    fifo_q.push_back(16'($urandom));
    fifo_q.push_back(16'($urandom));
    gate_closed = 1'b0;
    upd_fifo();
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("bp_valid_seen", out_valid, 1);
    repeat (5) begin
      step();
      chk("bp_valid_held", out_valid, 1);
      chk("bp_no_pop", fifo_rd_en, 0);
      if (exp_q.size() > 0) chk("bp_data_held", out_data, exp_q[0]);
    end
    out_ready = 1'b1;
    step();
    chk("pop_after_hs", fifo_rd_en, 1);
    drain(100);

    // Empty FIFO: nothing moves
    gate_closed = 1'b1;
    fifo_q.push_back(16'h5555);
    upd_fifo();
    repeat (20) begin
      step();
      chk("empty_rd_en", fifo_rd_en, 0);
      chk("empty_busy", busy, 0);
      chk("empty_valid", out_valid, 0);
    end
    fifo_q.delete();
    upd_fifo();

    // Coefficient write during MAC is ignored
    for (int i = 0; i < NT; i++) mh[i] = int'($signed(16'($urandom_range(0, 16'h3FFF))));
    load_mh();
    fifo_q.push_back(16'($urandom));
    fifo_q.push_back(16'h3000);
    gate_closed = 1'b0;
    out_ready = 1'b1;
    upd_fifo();
    wait_pop(20);
    step();
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'h7FFF;
    step();
    coef_we = 1'b0;
    drain(100);

    // Coefficient write in the same cycle as a pop takes effect
    gate_closed = 1'b1;
    fifo_q.push_back(16'($urandom));
    upd_fifo();
    v = 16'($urandom);
    mh[1]     = int'($signed(v));
    coef_we   = 1'b1;
    coef_addr = 3'd1;
    coef_data = v;
    gate_closed = 1'b0;
    upd_fifo();
    step();
    coef_we = 1'b0;
    drain(100);

    // Randomised traffic with FIFO gaps and downstream stalls
    for (int i = 0; i < NT; i++) mh[i] = int'($signed(16'($urandom)));
    gate_closed = 1'b1;
    upd_fifo();
    load_mh();
    repeat (60) fifo_q.push_back(16'($urandom));
    repeat (400) begin
      gate_closed = ($urandom_range(0, 3) == 0);
      out_ready   = 1'($urandom_range(0, 1));
      upd_fifo();
      step();
    end
    drain(2000);

    // Reset in the middle of a MAC pass
    for (int i = 0; i < NT; i++) mh[i] = 0;
    mh[0] = 32'h2000;
    mh[1] = 32'h1000;
    gate_closed = 1'b1;
    upd_fifo();
    load_mh();
    fifo_q.push_back(16'h4000);
    gate_closed = 1'b0;
    upd_fifo();
    wait_pop(20);
    step();
    step();
    rst = 1'b1;
    gate_closed = 1'b1;
    fifo_q.push_back(16'h7777);
    gate_closed = 1'b0;
    upd_fifo();
    chk("midrst_rd_en", fifo_rd_en, 0);
    step();
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    gate_closed = 1'b1;
    fifo_q.delete();
    upd_fifo();
    rst = 1'b0;
    exp_q.delete();
    model_reset();
    step();
    mh[0] = 32'h2000;
    mh[1] = 32'h1000;
    load_mh();
    fifo_q.push_back(16'h4000);
    fifo_q.push_back(16'h0000);
    drain(100);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_mac_engine.md
FIR_MAC_ENGINE -- requirements
Module: fir_mac_engine

Interface
REQ-001 Parameter NTAPS, default 8: number of filter taps, range 2..32.
REQ-002 Parameter DATA_W, default 16: sample and output width, signed two's complement.
REQ-003 Parameter COEF_W, default 16: coefficient width, signed Q1.15.
REQ-004 Parameter ACC_W, default 40: accumulator width.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 fifo_empty  input  1  upstream FIFO has no data.
REQ-009 fifo_rd_data  input  DATA_W  upstream head sample, valid whenever fifo_empty is low (show-ahead).
REQ-010 fifo_rd_en  output  1  pop strobe to upstream FIFO.
REQ-011 coef_we  input  1  coefficient write strobe.
REQ-012 coef_addr  input  clog2(NTAPS)  tap index to write.
REQ-013 coef_data  input  COEF_W  coefficient value.
REQ-014 out_data  output  DATA_W  filtered sample.
REQ-015 out_valid  output  1  out_data holds a result.
REQ-016 out_ready  input  1  downstream accepts out_data.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, MAC, OUT.
REQ-019 fifo_rd_en SHALL be combinational: (state==IDLE) & ~fifo_empty & ~rst.
REQ-020 In the fifo_rd_en cycle T, the delay line SHALL shift (x[0]<=fifo_rd_data, x[k]<=x[k-1]), the accumulator SHALL clear, and the state SHALL go to MAC.
REQ-021 In MAC, the block SHALL perform one signed multiply-accumulate per cycle, acc += x[i]*h[i] for i=0..NTAPS-1, over cycles T+1..T+NTAPS.
REQ-022 After the last tap, the state SHALL go to OUT; out_valid SHALL rise at cycle T+NTAPS+1 with out_data registered.
REQ-023 Output scaling SHALL be: (acc + 2^14) arithmetic-shifted right by 15, saturated to [-32768, 32767].
REQ-024 Products SHALL be full-width (DATA_W+COEF_W); the accumulator SHALL sign-extend and SHALL NOT wrap for NTAPS<=32.
REQ-025 In OUT, out_valid and out_data SHALL stay stable until out_valid & out_ready, then the state goes to IDLE; no FIFO pop occurs in OUT.
REQ-026 Throughput SHALL be one sample per NTAPS+2 cycles when out_ready is held high and the FIFO is non-empty.
REQ-027 If fifo_empty is high in IDLE, the block SHALL remain in IDLE with all state unchanged.
REQ-028 A coef_we in IDLE SHALL write h[coef_addr] at the next edge; coef_we in MAC or OUT SHALL be ignored.
REQ-029 If coef_we and fifo_rd_en occur in the same IDLE cycle, both SHALL take effect, and the new coefficient SHALL be used by the following MAC pass.

Reset
REQ-030 On rst, state SHALL go to IDLE; delay line, accumulator, out_data and all coefficients SHALL go to 0; out_valid SHALL be 0; fifo_rd_en SHALL be 0 during rst.
REQ-031 rst asserted mid-MAC or mid-OUT SHALL abort the result; the pending output is discarded and not presented.

Structure
REQ-032 Package fir_pkg SHALL hold DATA_W, COEF_W, ACC_W, the FRAC=15 shift constant, the saturation limits, and the state enum.
REQ-033 The multiply/accumulate/round/saturate datapath SHALL be a single sub-module, fir_mac; the FSM, delay line and coefficient registers SHALL live in fir_mac_engine.

Verification
REQ-034 Impulse test: h0=0x2000, h1=0x1000, others 0; input 0x4000 followed by 7 zeros -> outputs 0x1000, 0x0800, then 0x0000 x6.
REQ-035 Saturation test: all h=0x7FFF; 8 inputs of 0x7FFF -> 8th output 0x7FFF; then 8 inputs of 0x8000 -> 8th output 0x8000.
REQ-036 Backpressure test: out_ready low for 5 cycles in OUT -> out_valid held high, out_data constant, fifo_rd_en low; a pop occurs the cycle after the handshake.
REQ-037 Empty-FIFO test: fifo_empty high for 20 cycles -> fifo_rd_en never high, busy low, out_valid low.
REQ-038 Coefficient-while-busy test: coef_we (addr 0, 0x7FFF) during MAC -> h0 unchanged, current and next results match the old coefficients.
REQ-039 Reset-mid-operation test: rst at cycle T+3 of a MAC pass -> next cycle busy=0, out_valid=0; a subsequent impulse yields a response with zero history.
